// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM state
// encoding and the hex glyph table in common-cathode form (segment on = 1).
package seven_seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  // Segment order {a,b,c,d,e,f,g}, a in the MSB.
  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;
  localparam logic [6:0] GLYPH_A = 7'b1110111;
  localparam logic [6:0] GLYPH_B = 7'b0011111;
  localparam logic [6:0] GLYPH_C = 7'b1001110;
  localparam logic [6:0] GLYPH_D = 7'b0111101;
  localparam logic [6:0] GLYPH_E = 7'b1001111;
  localparam logic [6:0] GLYPH_F = 7'b1000111;

  // Hex nibble to common-cathode glyph.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_hex_7seg_decoder.sv
// Combinational hex-to-seven-segment decoder with selectable polarity.
module hex_7seg_decoder
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned common_anode_cathode = 1
) (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  logic [6:0] glyph;

  // Look up the glyph and apply segment polarity.
  always_comb begin
    glyph = hex_glyph(i_nibble);
    if (common_anode_cathode != 0) begin
      o_seg = glyph;
    end else begin
      o_seg = ~glyph;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller. Each digit slot is CLK_DIV
// cycles: BLANK_CYCLES dark (anti-ghosting) then the digit is driven.
// New data is double-buffered and only swapped in at a frame boundary.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS           = 4,
  parameter int unsigned CLK_DIV              = 50000,
  parameter int unsigned BLANK_CYCLES         = 500,
  parameter int unsigned common_anode_cathode = 0,
  parameter int unsigned DIGIT_ACTIVE_LOW     = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_blank_lz,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic [6:0]            SEG_OFF = (common_anode_cathode != 0) ? 7'h00 : 7'h7F;
  localparam logic                  DP_OFF  = (common_anode_cathode != 0) ? 1'b0 : 1'b1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (DIGIT_ACTIVE_LOW != 0) ?
                                              {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  // Reset synchroniser: assertion is immediate, release aligned to i_clk.
  logic rst_meta_q;
  logic rst_sync_q;

  scan_state_e state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    ready_q, ready_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    accept;
  logic                    wrap;
  logic                    load;
  logic                    above_zero;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic [3:0]              sel_nib;
  logic                    sel_dp;
  logic                    sel_lz;
  logic [6:0]              glyph_cc;
  logic                    dark;
  logic [6:0]              seg_on;
  logic                    dp_on;
  logic [NUM_DIGITS-1:0]   an_on;

  // Two-stage reset synchroniser.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Scan FSM next state: slot counter runs across BLANK and ON of one digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!i_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_ON;
          end
        end
        ST_ON: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Pending/display double buffer; display only changes at a frame wrap or in IDLE.
  always_comb begin
    accept      = i_valid & ready_q;
    wrap        = (state_q == ST_ON) && (idx_q == IDX_LAST) && (cnt_q == CNT_LAST);
    load        = ~ready_q & (wrap | (state_q == ST_IDLE));
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    ready_d     = ready_q;
    if (accept) begin
      pend_data_d = i_data;
      pend_dp_d   = i_dp;
      ready_d     = 1'b0;
    end
    if (load) begin
      disp_data_d = pend_data_q;
      disp_dp_d   = pend_dp_q;
      ready_d     = 1'b1;
    end
  end

  // Leading-zero mask and digit selection, both from next-cycle values so the
  // registered outputs line up with the registered state.
  always_comb begin
    lz_mask    = '0;
    above_zero = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS - 1; j++) begin
      above_zero = above_zero & (disp_data_d[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      lz_mask[NUM_DIGITS-1-j] = above_zero & i_blank_lz;
    end
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_lz    = 1'b0;
    an_onehot = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        sel_nib      = disp_data_d[4*k +: 4];
        sel_dp       = disp_dp_d[k];
        sel_lz       = lz_mask[k];
        an_onehot[k] = 1'b1;
      end
    end
  end

  hex_7seg_decoder #(
    .common_anode_cathode(1)
  ) u_dec (
    .i_nibble(sel_nib),
    .o_seg   (glyph_cc)
  );

  // Output register inputs: active-high forms first, polarity applied last.
  always_comb begin
    dark         = (state_d == ST_IDLE) | sel_lz;
    seg_on       = dark ? 7'h00 : glyph_cc;
    dp_on        = ~dark & sel_dp;
    an_on        = ((state_d == ST_ON) && !sel_lz) ? an_onehot : '0;
    seg_d        = (common_anode_cathode != 0) ? seg_on : ~seg_on;
    dp_d         = (common_anode_cathode != 0) ? dp_on : ~dp_on;
    an_d         = (DIGIT_ACTIVE_LOW != 0) ? ~an_on : an_on;
    frame_done_d = (state_d == ST_ON) && (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
  end

  // State, buffers and output registers.
  always_ff @(posedge i_clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      ready_q      <= 1'b1;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      ready_q      <= ready_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_seg        = seg_q;
  assign o_dp         = dp_q;
  assign o_an         = an_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: CLK_DIV=8, BLANK_CYCLES=2,
// four digits, common anode, active-low digit enables.
module tb_seven_seg_scan_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_en;
  logic [15:0] i_data;
  logic [3:0]  i_dp;
  logic        i_valid;
  logic        o_ready;
  logic        i_blank_lz;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_frame_done;

  int tests_run    = 0;
  int tests_failed = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .CLK_DIV(8),
    .BLANK_CYCLES(2),
    .common_anode_cathode(0),
    .DIGIT_ACTIVE_LOW(1)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_data      (i_data),
    .i_dp        (i_dp),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_blank_lz  (i_blank_lz),
    .o_seg       (o_seg),
    .o_dp        (o_dp),
    .o_an        (o_an),
    .o_frame_done(o_frame_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    int unsigned digit;
    logic [6:0]  seg;
    logic        dpo;
    logic [3:0]  an;
  } vec_t;

  vec_t vecs [24];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s #%0d: got 'h%0h, expected 'h%0h", name, idx, act, exp);
    end
  endtask

  // Stop scanning, offer data, and let IDLE copy it to the display register.
  task automatic load_idle(input logic [15:0] data, input logic [3:0] dp);
    i_en = 1'b0;
    tick();
    tick();
    i_data  = data;
    i_dp    = dp;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
  endtask

  int          fd_ticks [$];
  int          fd_cnt;
  logic        ready_low_ok;
  logic        seen;

  initial begin
    // {data, dp, lz, digit, seg (active-low), dp out, an}
    vecs[0]  = '{16'h1234, 4'h0, 1'b0, 0, 7'b1001100, 1'b1, 4'b1110};
    vecs[1]  = '{16'h1234, 4'h0, 1'b0, 1, 7'b0000110, 1'b1, 4'b1101};
    vecs[2]  = '{16'h1234, 4'h0, 1'b0, 2, 7'b0010010, 1'b1, 4'b1011};
    vecs[3]  = '{16'h1234, 4'h0, 1'b0, 3, 7'b1001111, 1'b1, 4'b0111};
    vecs[4]  = '{16'hABCD, 4'h5, 1'b0, 0, 7'b1000010, 1'b0, 4'b1110};
    vecs[5]  = '{16'hABCD, 4'h5, 1'b0, 1, 7'b0110001, 1'b1, 4'b1101};
    vecs[6]  = '{16'hABCD, 4'h5, 1'b0, 2, 7'b1100000, 1'b0, 4'b1011};
    vecs[7]  = '{16'hABCD, 4'h5, 1'b0, 3, 7'b0001000, 1'b1, 4'b0111};
    vecs[8]  = '{16'h0050, 4'h0, 1'b1, 3, 7'b1111111, 1'b1, 4'b1111};
    vecs[9]  = '{16'h0050, 4'h0, 1'b1, 2, 7'b1111111, 1'b1, 4'b1111};
    vecs[10] = '{16'h0050, 4'h0, 1'b1, 1, 7'b0100100, 1'b1, 4'b1101};
    vecs[11] = '{16'h0050, 4'h0, 1'b1, 0, 7'b0000001, 1'b1, 4'b1110};
    vecs[12] = '{16'h0050, 4'h0, 1'b0, 3, 7'b0000001, 1'b1, 4'b0111};
    vecs[13] = '{16'h0000, 4'hF, 1'b1, 0, 7'b0000001, 1'b0, 4'b1110};
    vecs[14] = '{16'h0000, 4'hF, 1'b1, 1, 7'b1111111, 1'b1, 4'b1111};
    vecs[15] = '{16'h8E6F, 4'h0, 1'b0, 0, 7'b0111000, 1'b1, 4'b1110};
    vecs[16] = '{16'h8E6F, 4'h0, 1'b0, 1, 7'b0100000, 1'b1, 4'b1101};
    vecs[17] = '{16'h8E6F, 4'h0, 1'b0, 2, 7'b0110000, 1'b1, 4'b1011};
    vecs[18] = '{16'h8E6F, 4'h0, 1'b0, 3, 7'b0000000, 1'b1, 4'b0111};
    vecs[19] = '{16'h7900, 4'h0, 1'b1, 0, 7'b0000001, 1'b1, 4'b1110};
    vecs[20] = '{16'h7900, 4'h0, 1'b1, 2, 7'b0000100, 1'b1, 4'b1011};
    vecs[21] = '{16'h7900, 4'h0, 1'b1, 3, 7'b0001111, 1'b1, 4'b0111};
    vecs[22] = '{16'h0100, 4'h8, 1'b1, 3, 7'b1111111, 1'b1, 4'b1111};
    vecs[23] = '{16'h0100, 4'h8, 1'b1, 1, 7'b0000001, 1'b1, 4'b1101};

    i_rst_n    = 1'b0;
    i_en       = 1'b0;
    i_data     = '0;
    i_dp       = '0;
    i_valid    = 1'b0;
    i_blank_lz = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_an",    0, 32'(o_an), 32'h0000000F);
    chk("rst_seg",   0, 32'(o_seg), 32'h0000007F);
    chk("rst_dp",    0, 32'(o_dp), 32'd1);
    chk("rst_ready", 0, 32'(o_ready), 32'd1);
    chk("rst_fd",    0, 32'(o_frame_done), 32'd0);
    i_rst_n = 1'b1;
    repeat (4) tick();

    // Table: blank cycle 0 of the slot, then first ON cycle (slot cycle 2)
    for (int i = 0; i < 24; i++) begin
      i_blank_lz = vecs[i].lz;
      load_idle(vecs[i].data, vecs[i].dp);
      i_en = 1'b1;
      repeat (vecs[i].digit * 8 + 1) tick();
      chk("vec_blank_an",  i, 32'(o_an), 32'h0000000F);
      chk("vec_blank_seg", i, 32'(o_seg), 32'(vecs[i].seg));
      chk("vec_blank_dp",  i, 32'(o_dp), 32'(vecs[i].dpo));
      repeat (2) tick();
      chk("vec_on_an",  i, 32'(o_an), 32'(vecs[i].an));
      chk("vec_on_seg", i, 32'(o_seg), 32'(vecs[i].seg));
      chk("vec_on_dp",  i, 32'(o_dp), 32'(vecs[i].dpo));
    end
    i_blank_lz = 1'b0;

    // Frame-done period: pulses at 32, 64, 96 cycles after enable
    load_idle(16'h1234, 4'h0);
    i_en = 1'b1;
    fd_ticks.delete();
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (o_frame_done === 1'b1) fd_ticks.push_back(t);
    end
    chk("fd_count", 0, 32'(fd_ticks.size()), 32'd3);
    for (int i = 0; i < fd_ticks.size() && i < 3; i++) begin
      chk("fd_pos", i, 32'(fd_ticks[i]), 32'(32 * (i + 1)));
    end

    // Handshake: update mid-frame, second update held until after wrap
    load_idle(16'h1234, 4'h0);
    i_en = 1'b1;
    ready_low_ok = 1'b1;
    for (int t = 1; t <= 70; t++) begin
      tick();
      if (t == 10) begin
        chk("hs_ready_idle", t, 32'(o_ready), 32'd1);
        i_data  = 16'hABCD;
        i_valid = 1'b1;
      end
      if (t == 11) i_data = 16'h0F0F;
      if (t >= 11 && t <= 32 && o_ready !== 1'b0) ready_low_ok = 1'b0;
      if (t == 27) begin
        chk("hs_old_seg", t, 32'(o_seg), 32'b1001111);
        chk("hs_old_an",  t, 32'(o_an), 32'b0111);
      end
      if (t == 33) begin
        chk("hs_ready_wrap", t, 32'(o_ready), 32'd1);
        chk("hs_new_seg_blank", t, 32'(o_seg), 32'b1000010);
      end
      if (t == 34) begin
        chk("hs_accept_0f0f", t, 32'(o_ready), 32'd0);
        i_valid = 1'b0;
      end
      if (t == 35) begin
        chk("hs_new_seg", t, 32'(o_seg), 32'b1000010);
        chk("hs_new_an",  t, 32'(o_an), 32'b1110);
      end
      if (t == 59) begin
        chk("hs_new_d3_seg", t, 32'(o_seg), 32'b0001000);
        chk("hs_new_d3_an",  t, 32'(o_an), 32'b0111);
      end
      if (t == 65) chk("hs_f3_seg_blank", t, 32'(o_seg), 32'b0111000);
      if (t == 67) begin
        chk("hs_f3_seg", t, 32'(o_seg), 32'b0111000);
        chk("hs_f3_an",  t, 32'(o_an), 32'b1110);
      end
    end
    chk("hs_ready_held_low", 0, 32'(ready_low_ok), 32'd1);

    // Enable abort during digit 2 ON
    load_idle(16'h1234, 4'h0);
    i_en = 1'b1;
    repeat (19) tick();
    chk("ab_pre_an",  0, 32'(o_an), 32'b1011);
    chk("ab_pre_seg", 0, 32'(o_seg), 32'b0010010);
    i_en = 1'b0;
    tick();
    chk("ab_an",  0, 32'(o_an), 32'h0000000F);
    chk("ab_seg", 0, 32'(o_seg), 32'h0000007F);
    chk("ab_dp",  0, 32'(o_dp), 32'd1);
    fd_cnt = (o_frame_done === 1'b1) ? 1 : 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (o_frame_done === 1'b1) fd_cnt++;
    end
    chk("ab_no_fd", 0, 32'(fd_cnt), 32'd0);
    i_en = 1'b1;
    tick();
    chk("ab_re_c0_an",  0, 32'(o_an), 32'h0000000F);
    chk("ab_re_c0_seg", 0, 32'(o_seg), 32'b1001100);
    tick();
    chk("ab_re_c1_an",  0, 32'(o_an), 32'h0000000F);
    tick();
    chk("ab_re_c2_an",  0, 32'(o_an), 32'b1110);
    chk("ab_re_c2_seg", 0, 32'(o_seg), 32'b1001100);

    // Asynchronous reset mid-frame with an update pending
    repeat (10) tick();
    i_data  = 16'h5555;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("rm_ready_pend", 0, 32'(o_ready), 32'd0);
    repeat (2) tick();
    i_rst_n = 1'b0;
    #2;
    chk("rm_an",    0, 32'(o_an), 32'h0000000F);
    chk("rm_seg",   0, 32'(o_seg), 32'h0000007F);
    chk("rm_dp",    0, 32'(o_dp), 32'd1);
    chk("rm_fd",    0, 32'(o_frame_done), 32'd0);
    chk("rm_ready", 0, 32'(o_ready), 32'd1);
    repeat (2) tick();
    i_rst_n = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      if (o_an === 4'b1110) seen = 1'b1;
    end
    chk("rm_restart_seen", 0, 32'(seen), 32'd1);
    chk("rm_restart_seg",  0, 32'(o_seg), 32'b0000001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
